// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, NOP encoding
// and the default boot address.
package if_pkg;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN
   } if_state_e;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [31:0] IF_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_stage_module_if_id_reg.sv
// IF/ID pipeline register: flush bubbles, load captures, stall holds,
// otherwise the entry drains to a bubble.
module if_id_reg
   import if_pkg::*;
#(
   parameter int NBits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic [NBits-1:0] pc_i,
   input  logic [NBits-1:0] pc_4_i,
   input  logic [NBits-1:0] instr_i,
   output logic [NBits-1:0] pc_o,
   output logic [NBits-1:0] pc_4_o,
   output logic [NBits-1:0] instr_o,
   output logic             valid_o
);

   localparam logic [NBits-1:0] NOP = NBits'(NOP_INSTR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_o    <= '0;
         pc_4_o  <= '0;
         instr_o <= NOP;
         valid_o <= 1'b0;
      end else if (flush_i) begin
         instr_o <= NOP;
         valid_o <= 1'b0;
      end else if (load_i) begin
         pc_o    <= pc_i;
         pc_4_o  <= pc_4_i;
         instr_o <= instr_i;
         valid_o <= 1'b1;
      end else if (!stall_i) begin
         instr_o <= NOP;
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage_module.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID register.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module if_stage_module
   import if_pkg::*;
#(
   parameter int               NBits    = 32,
   parameter logic [NBits-1:0] RESET_PC = NBits'(IF_RESET_PC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             redirect_i,
   input  logic [NBits-1:0] redirect_pc_i,
   output logic             imem_req_o,
   output logic [NBits-1:0] imem_addr_o,
   input  logic [NBits-1:0] imem_rdata_i,
   input  logic             imem_valid_i,
   output logic [NBits-1:0] IF_ID_pc_o,
   output logic [NBits-1:0] IF_ID_pc_4_o,
   output logic [NBits-1:0] IF_ID_instr_o,
   output logic             IF_ID_valid_o
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0]      fetch_count_o,
   output logic [31:0]      stall_count_o
`endif
);

   localparam logic [NBits-1:0] FOUR = NBits'(4);

   if_state_e        state_q, state_d;
   logic [NBits-1:0] pc_q, pc_d;
   logic [NBits-1:0] buf_q, buf_d;
   logic [NBits-1:0] drain_addr_q, drain_addr_d;
   logic [NBits-1:0] pc_plus4;
   logic             load;
   logic [NBits-1:0] load_instr;

   assign pc_plus4 = pc_q + FOUR;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         buf_q        <= '0;
         drain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_q        <= buf_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_d        = buf_q;
      drain_addr_d = drain_addr_q;
      load         = 1'b0;
      load_instr   = imem_rdata_i;
      imem_req_o   = 1'b0;
      imem_addr_o  = pc_q;
      unique case (state_q)
         FETCH: begin
            imem_req_o = 1'b1;
            if (imem_valid_i) begin
               if (redirect_i) begin
                  pc_d = redirect_pc_i;
               end else if (stall_i) begin
                  buf_d   = imem_rdata_i;
                  state_d = HOLD;
               end else begin
                  load = 1'b1;
                  pc_d = pc_plus4;
               end
            end else if (redirect_i) begin
               // The in-flight request keeps its address until its response is swallowed.
               pc_d         = redirect_pc_i;
               drain_addr_d = pc_q;
               state_d      = DRAIN;
            end
         end
         HOLD: begin
            load_instr = buf_q;
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               state_d = FETCH;
            end else if (!stall_i) begin
               load    = 1'b1;
               pc_d    = pc_plus4;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            imem_req_o  = 1'b1;
            imem_addr_o = drain_addr_q;
            if (redirect_i) pc_d = redirect_pc_i;
            if (imem_valid_i) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   if_id_reg #(.NBits(NBits)) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .load_i  (load),
      .pc_i    (pc_q),
      .pc_4_i  (pc_plus4),
      .instr_i (load_instr),
      .pc_o    (IF_ID_pc_o),
      .pc_4_o  (IF_ID_pc_4_o),
      .instr_o (IF_ID_instr_o),
      .valid_o (IF_ID_valid_o)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count_o <= '0;
         stall_count_o <= '0;
      end else begin
         if (load && !flush_i) fetch_count_o <= fetch_count_o + 32'd1;
         if (stall_i)          stall_count_o <= stall_count_o + 32'd1;
      end
   end
`endif

endmodule
